// File: rtl/tile_sched_pkg.sv
// rtl/tile_sched_pkg.sv - shared grid geometry, tile type width, scheduler states and tile index helper
package tile_sched_pkg;

  localparam int GRID_W  = 15;
  localparam int GRID_H  = 15;
  localparam int TYPE_W  = 7;
  localparam int COORD_W = 5;
  localparam int NTILES  = GRID_W * GRID_H;
  localparam int IDX_W   = 8;

  localparam logic [TYPE_W-1:0] TYPE_BLACK = '0;

  typedef enum logic [1:0] {
    SCAN,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } sched_state_e;

  // Raster index of a tile: row-major, y * GRID_W + x.
  function automatic logic [IDX_W-1:0] tile_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
  endfunction

endpackage

// File: rtl/tile_xy_counter.sv
// rtl/tile_xy_counter.sv - round-robin (sx,sy) scan pointer over the tile grid
module tile_xy_counter
  import tile_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [COORD_W-1:0] sx,
  output logic [COORD_W-1:0] sy
);

  logic [COORD_W-1:0] sx_q, sx_d;
  logic [COORD_W-1:0] sy_q, sy_d;

  // Next pointer: step x, wrap x into the next row, wrap the last tile back to (0,0).
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (advance) begin
      if (sx_q == COORD_W'(GRID_W - 1)) begin
        sx_d = '0;
        sy_d = (sy_q == COORD_W'(GRID_H - 1)) ? '0 : sy_q + COORD_W'(1);
      end else begin
        sx_d = sx_q + COORD_W'(1);
      end
    end
  end

  // Pointer registers, starting at (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

  assign sx = sx_q;
  assign sy = sy_q;

endmodule

// File: rtl/tile_draw_scheduler.sv
// rtl/tile_draw_scheduler.sv - tile type/dirty table and copy-engine job sequencer (option: TILE_SCHED_SKIP_SAME_EN)
module tile_draw_scheduler
  import tile_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  input  logic [TYPE_W-1:0]  req_type,
  input  logic               refresh,
  output logic               busy,
  output logic               cp_en,
  input  logic               cp_rdy,
  output logic [COORD_W-1:0] cp_x,
  output logic [COORD_W-1:0] cp_y,
  output logic [TYPE_W-1:0]  cp_type
);

  logic [TYPE_W-1:0]  type_q [NTILES];
  logic [TYPE_W-1:0]  type_d [NTILES];
  logic [NTILES-1:0]  dirty_q, dirty_d;

  sched_state_e       state_q, state_d;
  logic               cp_en_q, cp_en_d;
  logic [COORD_W-1:0] cp_x_q, cp_x_d, cp_y_q, cp_y_d;
  logic [TYPE_W-1:0]  cp_type_q, cp_type_d;

  logic [COORD_W-1:0] sx, sy;
  logic [IDX_W-1:0]   scan_idx, req_idx;
  logic               req_hit, req_mark, take, advance;

  tile_xy_counter u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .sx      (sx),
    .sy      (sy)
  );

  assign scan_idx = tile_idx(sx, sy);
  assign req_idx  = tile_idx(req_x, req_y);
  assign req_hit  = req_valid && (req_x < COORD_W'(GRID_W)) && (req_y < COORD_W'(GRID_H));
`ifdef TILE_SCHED_SKIP_SAME_EN
  assign req_mark = req_hit && (req_type != type_q[req_idx]);
`else
  assign req_mark = req_hit;
`endif
  assign take = (state_q == SCAN) && dirty_q[scan_idx];

  // Table update: clear on job latch first, so refresh and a request to the same tile win.
  always_comb begin
    type_d  = type_q;
    dirty_d = dirty_q;
    if (take)     dirty_d[scan_idx] = 1'b0;
    if (refresh)  dirty_d = '1;
    if (req_hit)  type_d[req_idx] = req_type;
    if (req_mark) dirty_d[req_idx] = 1'b1;
  end

  // Table registers: black everywhere, all dirty so the first frame paints every tile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NTILES; i++) type_q[i] <= TYPE_BLACK;
      dirty_q <= '1;
    end else begin
      type_q  <= type_d;
      dirty_q <= dirty_d;
    end
  end

  // Job sequencing: latch a dirty tile, handshake once, then track the engine's rdy low/high.
  always_comb begin
    state_d   = state_q;
    cp_en_d   = cp_en_q;
    cp_x_d    = cp_x_q;
    cp_y_d    = cp_y_q;
    cp_type_d = cp_type_q;
    advance   = 1'b0;
    case (state_q)
      SCAN: begin
        if (take) begin
          cp_x_d    = sx;
          cp_y_d    = sy;
          cp_type_d = type_q[scan_idx];
          cp_en_d   = 1'b1;
          state_d   = ISSUE;
        end else begin
          advance = 1'b1;
        end
      end
      ISSUE: begin
        if (cp_rdy) begin
          cp_en_d = 1'b0;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!cp_rdy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (cp_rdy) begin
          advance = 1'b1;
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // FSM and registered job outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      cp_en_q   <= 1'b0;
      cp_x_q    <= '0;
      cp_y_q    <= '0;
      cp_type_q <= TYPE_BLACK;
    end else begin
      state_q   <= state_d;
      cp_en_q   <= cp_en_d;
      cp_x_q    <= cp_x_d;
      cp_y_q    <= cp_y_d;
      cp_type_q <= cp_type_d;
    end
  end

  assign busy    = (|dirty_q) || (state_q != SCAN);
  assign cp_en   = cp_en_q;
  assign cp_x    = cp_x_q;
  assign cp_y    = cp_y_q;
  assign cp_type = cp_type_q;

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// tb/tb_tile_draw_scheduler.sv - self-checking bench with copy-engine model and tile table reference
module tb_tile_draw_scheduler;

  localparam int GW = 15;
  localparam int NT = 225;
  localparam int MAXJ = 2048;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] req_x = '0, req_y = '0;
  logic [6:0] req_type = '0;
  logic       refresh = 1'b0;
  logic       busy, cp_en;
  logic       cp_rdy = 1'b1;
  logic [4:0] cp_x, cp_y;
  logic [6:0] cp_type;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int         njobs = 0;
  logic [4:0] jx [MAXJ];
  logic [4:0] jy [MAXJ];
  logic [6:0] jt [MAXJ];
  int         jen [MAXJ];
  bit         jstable [MAXJ];

  logic [6:0] mtype [NT];
  logic [6:0] drawn [NT];

  int phase = 0;
  int cnt = 0;
  int en_count = 0;
  int base;

  tile_draw_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_type  (req_type),
    .refresh   (refresh),
    .busy      (busy),
    .cp_en     (cp_en),
    .cp_rdy    (cp_rdy),
    .cp_x      (cp_x),
    .cp_y      (cp_y),
    .cp_type   (cp_type)
  );

  initial forever #5 clk = ~clk;

  // Copy engine: accepts on cp_en&&rdy, drops rdy for 3 cycles, logs every job.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cp_rdy = 1'b1;
        phase = 0;
        cnt = 0;
        en_count = 0;
      end else begin
        if (phase != 0 && njobs > 0) begin
          if (cp_x !== jx[njobs-1] || cp_y !== jy[njobs-1] || cp_type !== jt[njobs-1])
            jstable[njobs-1] = 1'b0;
        end
        if (phase == 1) begin
          phase = 2;
          cp_rdy = 1'b0;
          cnt = 3;
        end else if (phase == 2) begin
          cnt--;
          if (cnt == 0) begin
            cp_rdy = 1'b1;
            phase = 0;
          end
        end else begin
          if (cp_en === 1'b1) en_count++;
          if (cp_en === 1'b1 && cp_rdy && njobs < MAXJ) begin
            jx[njobs] = cp_x;
            jy[njobs] = cp_y;
            jt[njobs] = cp_type;
            jen[njobs] = en_count;
            jstable[njobs] = 1'b1;
            if (cp_x < 5'd15 && cp_y < 5'd15) drawn[int'(cp_y) * GW + int'(cp_x)] = cp_type;
            njobs++;
            en_count = 0;
            phase = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic post(input int x, input int y, input int t, input bit rf);
    step();
    req_valid = 1'b1;
    req_x = x[4:0];
    req_y = y[4:0];
    req_type = t[6:0];
    refresh = rf;
    step();
    req_valid = 1'b0;
    refresh = 1'b0;
    if (x < GW && y < GW) mtype[y * GW + x] = t[6:0];
  endtask

  task automatic wait_idle(input string tag, input int max);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (busy !== 1'b0 && c < max);
    chk({tag, "_idle_timeout"}, 32'(c < max), 32'd1);
  endtask

  task automatic wait_job(input string tag, input int x, input int y);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (!(phase == 2 && njobs > 0 && int'(jx[njobs-1]) == x && int'(jy[njobs-1]) == y) && c < 600);
    chk({tag, "_job_timeout"}, 32'(c < 600), 32'd1);
  endtask

  // Expect 225 jobs in raster order from tile index 'start', each with the modelled type.
  task automatic check_raster(input string tag, input int first, input int start);
    chk({tag, "_count"}, 32'(njobs - first), 32'd225);
    for (int k = 0; k < NT; k++) begin
      int idx;
      int j;
      idx = (start + k) % NT;
      j = (first + k) % MAXJ;
      chk({tag, "_job"}, 32'({jstable[j], jx[j], jy[j], jt[j]}),
          32'({1'b1, 5'(idx % GW), 5'(idx / GW), mtype[idx]}));
    end
  endtask

  initial begin
    int busy_hits;
    int x, y, t;
    for (int i = 0; i < NT; i++) begin
      mtype[i] = 7'd0;
      drawn[i] = 7'h7f;
    end

    // Reset values
    step();
    step();
    chk("rst_cp_en", 32'(cp_en), 32'd0);
    chk("rst_cp_xy", 32'({cp_x, cp_y}), 32'd0);
    chk("rst_cp_type", 32'(cp_type), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;

    // Reset paint: 225 black tiles in raster order
    base = njobs;
    wait_idle("paint", 4000);
    check_raster("paint", base, 0);
    chk("paint_busy", 32'(busy), 32'd0);

    // Update during an in-flight copy of the same tile
    base = njobs;
    post(3, 4, 5, 1'b0);
    wait_job("inflight", 3, 4);
    post(3, 4, 7, 1'b0);
    wait_idle("inflight", 1000);
    chk("inflight_count", 32'(njobs - base), 32'd2);
    chk("inflight_first", 32'({jstable[base], jx[base], jy[base], jt[base]}), 32'({1'b1, 5'd3, 5'd4, 7'd5}));
    chk("inflight_second", 32'({jstable[base+1], jx[base+1], jy[base+1], jt[base+1]}), 32'({1'b1, 5'd3, 5'd4, 7'd7}));

    // Single update with an idle engine
    base = njobs;
    post(3, 4, 5, 1'b0);
    wait_idle("single", 600);
    chk("single_count", 32'(njobs - base), 32'd1);
    chk("single_job", 32'({jx[base], jy[base], jt[base]}), 32'({5'd3, 5'd4, 7'd5}));
    chk("single_en_cycles", 32'(jen[base]), 32'd1);
    chk("single_stable", 32'(jstable[base]), 32'd1);

    // Out-of-range requests are dropped
    base = njobs;
    busy_hits = 0;
    post(15, 2, 9, 1'b0);
    if (busy !== 1'b0) busy_hits++;
    post(2, 15, 9, 1'b0);
    if (busy !== 1'b0) busy_hits++;
    post(15, 15, 9, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (busy !== 1'b0) busy_hits++;
    end
    chk("oor_busy_cycles", 32'(busy_hits), 32'd0);
    chk("oor_jobs", 32'(njobs - base), 32'd0);

    // Same-type request
    base = njobs;
    post(2, 2, 0, 1'b0);
    wait_idle("same", 600);
`ifdef TILE_SCHED_SKIP_SAME_EN
    chk("same_jobs", 32'(njobs - base), 32'd0);
`else
    chk("same_jobs", 32'(njobs - base), 32'd1);
`endif

    // Refresh during a copy of (7,7)
    base = njobs;
    post(7, 7, 9, 1'b0);
    wait_job("refresh", 7, 7);
    step();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    wait_idle("refresh", 4000);
    chk("refresh_first", 32'({jstable[base], jx[base], jy[base], jt[base]}), 32'({1'b1, 5'd7, 5'd7, 7'd9}));
    check_raster("refresh", base + 1, 7 * GW + 8);

    // Random updates, refreshes and out-of-range coordinates
    for (int i = 0; i < 60; i++) begin
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      t = $urandom_range(0, 127);
      post(x, y, t, ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 6)) step();
    end
    wait_idle("random", 20000);
    for (int i = 0; i < NT; i++) chk("random_drawn", 32'(drawn[i]), 32'(mtype[i]));

    // Reset in the middle of a copy
    post(5, 6, (int'(mtype[6 * GW + 5]) + 1) % 128, 1'b0);
    wait_job("midreset", 5, 6);
    rst_n = 1'b0;
    step();
    chk("midrst_cp_en", 32'(cp_en), 32'd0);
    chk("midrst_cp_xy", 32'({cp_x, cp_y}), 32'd0);
    chk("midrst_cp_type", 32'(cp_type), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    step();
    for (int i = 0; i < NT; i++) mtype[i] = 7'd0;
    base = njobs;
    rst_n = 1'b1;
    wait_idle("midreset", 4000);
    check_raster("midreset", base, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_draw_scheduler.md
# tile_draw_scheduler

Owns the 15x15 map tile table and sequences the single tile copy engine, which draws 29x29 or 20x20 tiles into the 640x480 frame buffer. Game logic posts tile updates here, and a full-screen refresh can be requested. The scheduler records a dirty bit per tile and scans the grid round-robin. For each dirty tile it issues exactly one copy job over the engine's en/rdy handshake. It holds that job's coordinates and type stable until the engine finishes.

## Interface
- GRID_W, 15, tiles per row (x 0..14)
- GRID_H, 15, tiles per column (y 0..14)
- TYPE_W, 7, tile type width (engine copytype)

- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- req_valid  in  1  tile update strobe
- req_x, req_y  in  5 each  tile coordinate
- req_type  in  TYPE_W  new tile type
- refresh  in  1  mark every tile dirty
- busy  out  1  any tile dirty or copy in flight
- cp_en  out  1  start strobe to copy engine
- cp_rdy  in  1  engine idle
- cp_x, cp_y  out  5 each  coordinate of the job in flight
- cp_type  out  TYPE_W  copytype of the job in flight

## Operation
- Table: GRID_W*GRID_H entries, each holding type[TYPE_W] and dirty.
- Reset sets every type to 0 (black) and every dirty bit to 1, so the first frame paints all tiles.
- Request handling: any cycle with req_valid=1 and req_x<GRID_W and req_y<GRID_H writes type and sets dirty. Out-of-range requests are dropped silently. There is no back-pressure.
- refresh=1 sets all dirty bits. Stored types are unchanged.
- FSM states:
  - SCAN: examines one entry per cycle at pointer (sx,sy). If the entry is dirty, latch cp_x/cp_y/cp_type from the table, clear its dirty bit, and go to ISSUE. Otherwise advance the pointer.
  - ISSUE: hold cp_en=1 until the cycle cp_rdy=1 is sampled. That handshake cycle is the only cycle with cp_en=1. Then go to WAIT_START.
  - WAIT_START: wait for cp_rdy=0.
  - WAIT_DONE: wait for cp_rdy=1, then advance the pointer past the served tile and go to SCAN.
- Pointer advance: sx increments. At sx=GRID_W-1 it wraps to 0 and sy increments. At (GRID_W-1, GRID_H-1) it wraps to (0,0).
- cp_x/cp_y/cp_type stay constant from ISSUE through WAIT_DONE. The engine re-derives addresses from them throughout the copy.
- busy = (OR of all dirty bits) | (state != SCAN).

## Timing
- Reset values: cp_en=0, cp_x=0, cp_y=0, cp_type=0, busy=1 (all dirty), state SCAN, pointer (0,0).
- Request to dirty: 1 cycle; the table updates on the edge after req_valid.
- Dirty tile found at pointer to cp_en=1: 1 cycle. cp_en stays 1 at most until cp_rdy=1.
- Worst-case scan latency for a single dirty tile with an idle engine is 225 cycles.
- Same-cycle request and dirty-clear on the entry being latched: the request wins. Dirty stays 1 and the type is updated. The issued job uses the pre-write type, and the tile is redrawn on a later pass.
- Request during a copy of the same tile: the tile is re-marked dirty and the current job is not disturbed.
- refresh and req_valid in the same cycle: both apply.
- Reset mid-copy: the FSM returns to SCAN with all tiles dirty. The engine is reset by the same rst_n.

## Configuration
- TILE_SCHED_SKIP_SAME_EN defined: a request whose req_type equals the stored type does not set dirty. refresh is unaffected.
- TILE_SCHED_SKIP_SAME_EN undefined: every in-range request sets dirty.

## Structure
- tile_sched_pkg holds:
  - GRID_W/GRID_H defaults and TYPE_W
  - TYPE_BLACK = 0
  - the state enum {SCAN, ISSUE, WAIT_START, WAIT_DONE}
- Sub-module tile_xy_counter: the (sx,sy) round-robin pointer with advance input and wrap logic.
- The table and FSM live in tile_draw_scheduler.

## Test plan
- Reset, engine model with 3-cycle rdy-low jobs -> 225 jobs issued in raster order (0,0),(1,0)..(14,14), all cp_type=0, then busy=0.
- Idle, req (3,4,type 5) -> exactly one job with cp_x=3, cp_y=4, cp_type=5, and cp_en high for one handshake cycle.
- Req (3,4,5) then req (3,4,7) while (3,4) is in flight -> the current job completes with type 5, then a second job runs with type 7.
- Req x=15 or y=15 -> no table change, no job, busy stays 0.
- With TILE_SCHED_SKIP_SAME_EN, req (2,2,0) after the reset paint -> no job; without the macro -> one job.
- refresh pulse mid-copy of (7,7) -> the current job finishes, then 225 further jobs are issued starting at (8,7) and wrapping to (7,7).
